ad9253_lane_align_ctrl: RTL and testbench
=========================================

# ad9253_lane_align_ctrl

Multi-lane successor to the single-lane AD9253 alignment controller. For each of LANES ADC data lanes it sweeps the input delay tap across the full range and records the longest contiguous window in which the frame-clock pattern matches. It then parks the tap at the centre of that window, or issues a bitslip and re-sweeps when no usable window exists. After every lane is trained it monitors lock, counts pattern errors per lane, and retrains automatically when a lane exceeds its error limit. It sits between the AD9253 deserialiser lanes (pattern in, delay/bitslip out) and the acquisition control logic.

## Interface
- LANES, 4, number of lanes trained, one at a time.
- DLY_W, 9, width of each delay tap value.
- DLY_MAX, 450, highest tap value swept.
- DLY_STEP, 10, tap increment between sweep points.
- SETTLE_CYC, 32, wait cycles after any tap change or bitslip before sampling.
- SAMPLE_CYC, 64, cycles checked per sweep point.
- PAT_W, 8, frame pattern width.
- FC_PATTERN, 8'hF0, expected aligned frame word.
- MIN_EYE, 3, minimum passing sweep points in a window for that window to be accepted.
- ERR_LIMIT, 16'h1000, per-lane mismatch count that triggers a retrain.
- clk  in  1  deserialiser word clock.
- rst  in  1  synchronous, active-high reset.
- cfg_rdy  in  1  ADC configured; training runs only while this is high.
- fc_patten  in  LANES*PAT_W  per-lane deserialised frame word; lane i occupies bits [i*PAT_W +: PAT_W].
- dly_cnt  out  LANES*DLY_W  per-lane delay tap, registered.
- bit_slip  out  LANES  one-cycle bitslip pulse per lane.
- lane_done  out  LANES  lane has been centred.
- lane_fail  out  LANES  lane found no eye after PAT_W slips.
- train_cpl  out  1  all lanes done, none failed.
- en_vtc  out  1  equals train_cpl.
- eye_width  out  LANES*8  best window length of each lane, in sweep points.
- retrain_cnt  out  16  number of automatic retrains, saturating.

## Operation
- Reset values: dly_cnt=0, bit_slip=0, lane_done=0, lane_fail=0, train_cpl=0, en_vtc=0, eye_width=0, retrain_cnt=0, lane index=0, FSM=IDLE.
- When cfg_rdy is low, the FSM goes to IDLE the next cycle, from any state. All outputs are cleared except retrain_cnt.
- FSM states:
  - IDLE: when cfg_rdy is high, clear the lane index and slip count, then go to SETTLE.
  - SETTLE: wait SETTLE_CYC cycles, then go to SAMPLE.
  - SAMPLE: check the current lane for SAMPLE_CYC cycles. The sweep point passes only if every sampled word equals FC_PATTERN. Then go to STEP.
  - STEP: update the window trackers, described below.
    - If dly_cnt+DLY_STEP is at most DLY_MAX, add DLY_STEP to dly_cnt and go to SETTLE.
    - Otherwise go to EVAL.
  - EVAL: if best_len is at least MIN_EYE, go to CENTER. Otherwise go to SLIP.
  - SLIP: pulse bit_slip for the current lane, set its dly_cnt to 0, and increment the slip count.
    - If the slip count reaches PAT_W, set lane_fail and go to NEXT.
    - Otherwise go to SETTLE.
  - CENTER: set dly_cnt = best_start + ((best_len-1)>>1)*DLY_STEP. Set lane_done and eye_width, then go to NEXT.
  - NEXT: if this is the last lane, go to MONITOR when no lane has failed, or to FAIL otherwise. Else move to the next lane, clear the trackers and slip count, and go to SETTLE.
  - MONITOR: train_cpl=1. Per-lane 16-bit mismatch counters increment on every cycle where that lane's word is not FC_PATTERN.
    - If any counter exceeds ERR_LIMIT, increment retrain_cnt and go to IDLE. This clears all lane state and the tap values.
  - FAIL: terminal. Only rst or a falling cfg_rdy leaves it.
- Window tracking (8-bit counters):
  - On a pass: if cur_len==0, set cur_start=dly_cnt. Then increment cur_len. If cur_len (after increment) > best_len, copy cur_start and cur_len into best_start and best_len.
  - On a fail: clear cur_len.
  - Ties: the strict > comparison keeps the first (lowest-tap) window.
- Arithmetic: the CENTER product is at most DLY_MAX and fits in DLY_W bits. Mismatch counters saturate at 16'hFFFF.

## Timing
- Per sweep point: SETTLE_CYC + SAMPLE_CYC + 1 cycles. With defaults that is 97 cycles × 46 points ≈ 4.5k cycles per lane sweep.
- bit_slip is high for exactly one cycle, in the SLIP state. The next sample starts no earlier than SETTLE_CYC cycles after it.
- dly_cnt changes only in STEP, SLIP, CENTER, and when leaving IDLE. It changes only on the lane under training; the taps of other lanes are held.
- train_cpl and en_vtc rise one cycle after the last lane's NEXT state. They fall one cycle after a retrain trigger.
- If rst and cfg_rdy are asserted in the same cycle, rst wins.

## Test plan
- Lane 0 passes at taps 100–200 and lanes 1–3 pass at 50–90. Required result: dly_cnt lane0=150, lane1..3=70; eye_width = 11 and 5; train_cpl=1; no bit_slip pulses.
- Lane 2 never passes for 3 slips, then passes at 0–40. Required result: exactly 3 bit_slip[2] pulses, each one cycle wide; final dly_cnt[2]=20; lane_fail=0.
- Lane 1 never passes. Required result: 8 bit_slip[1] pulses; lane_fail[1]=1; FSM reaches FAIL; train_cpl stays 0.
- Two equal windows on lane 0, at 0–20 and 300–320. Required result: dly_cnt[0]=10, since the first window wins the tie.
- After train_cpl, corrupt lane 3 for 4097 cycles. Required result: retrain_cnt increments to 1, train_cpl drops, and a full retrain completes with the same taps.
- Deassert cfg_rdy mid-sweep, then assert rst mid-MONITOR. Required result: all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/ad9253_lane_align_ctrl.sv
// Per-lane AD9253 frame alignment: sweep delay taps, centre on the widest passing
// window (or bitslip and re-sweep), then watch lock and retrain on excessive errors.
//
//   state   | meaning
//   IDLE    | waiting for cfg_rdy; taps and lane state cleared
//   SETTLE  | tap/bitslip settling wait
//   SAMPLE  | compare the current lane's word against the frame pattern
//   STEP    | update window trackers, advance the tap or finish the sweep
//   EVAL    | decide between centring and bitslip
//   SLIP    | bitslip pulse, tap back to zero, restart the sweep
//   CENTER  | park tap in the middle of the best window
//   NEXT    | move to the next lane or finish training
//   MONITOR | trained; per-lane mismatch counting
//   FAIL    | at least one lane has no eye; terminal
module ad9253_lane_align_ctrl #(
    parameter int              LANES      = 4,
    parameter int              DLY_W      = 9,
    parameter int              DLY_MAX    = 450,
    parameter int              DLY_STEP   = 10,
    parameter int              SETTLE_CYC = 32,
    parameter int              SAMPLE_CYC = 64,
    parameter int              PAT_W      = 8,
    parameter logic [PAT_W-1:0] FC_PATTERN = 8'hF0,
    parameter int              MIN_EYE    = 3,
    parameter logic [15:0]     ERR_LIMIT  = 16'h1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_rdy,
    input  logic [LANES*PAT_W-1:0] fc_patten,
    output logic [LANES*DLY_W-1:0] dly_cnt,
    output logic [LANES-1:0]       bit_slip,
    output logic [LANES-1:0]       lane_done,
    output logic [LANES-1:0]       lane_fail,
    output logic                   train_cpl,
    output logic                   en_vtc,
    output logic [LANES*8-1:0]     eye_width,
    output logic [15:0]            retrain_cnt
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SLIP_W = $clog2(PAT_W + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETTLE, S_SAMPLE, S_STEP, S_EVAL,
        S_SLIP, S_CENTER, S_NEXT, S_MONITOR, S_FAIL
    } state_t;

    state_t            state;
    logic [LANE_W-1:0] lane;
    logic [SLIP_W-1:0] slip_cnt;
    logic [15:0]       tmr;
    logic              pass_ok;
    logic [7:0]        cur_len, best_len;
    logic [DLY_W-1:0]  cur_start, best_start;
    logic [15:0]       err_cnt [LANES];

    logic [PAT_W-1:0]  cur_word;
    logic [DLY_W-1:0]  cur_dly;
    logic [DLY_W:0]    next_dly;
    logic [7:0]        new_len, half_len;
    logic [DLY_W-1:0]  new_start, center_dly;
    logic              err_over;

    assign cur_word   = fc_patten[lane*PAT_W +: PAT_W];
    assign cur_dly    = dly_cnt[lane*DLY_W +: DLY_W];
    assign next_dly   = {1'b0, cur_dly} + (DLY_W+1)'(DLY_STEP);
    assign new_len    = cur_len + 8'd1;
    assign new_start  = (cur_len == 8'd0) ? cur_dly : cur_start;
    assign half_len   = (best_len - 8'd1) >> 1;
    assign center_dly = best_start + DLY_W'(int'(half_len) * DLY_STEP);

    always_comb begin
        err_over = 1'b0;
        for (int i = 0; i < LANES; i++)
            if (err_cnt[i] > ERR_LIMIT) err_over = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lane        <= '0;
            slip_cnt    <= '0;
            tmr         <= '0;
            pass_ok     <= 1'b1;
            cur_len     <= '0;
            best_len    <= '0;
            cur_start   <= '0;
            best_start  <= '0;
            dly_cnt     <= '0;
            bit_slip    <= '0;
            lane_done   <= '0;
            lane_fail   <= '0;
            train_cpl   <= 1'b0;
            en_vtc      <= 1'b0;
            eye_width   <= '0;
            retrain_cnt <= '0;
            for (int i = 0; i < LANES; i++) err_cnt[i] <= '0;
        end else if (!cfg_rdy) begin
            state     <= S_IDLE;
            dly_cnt   <= '0;
            bit_slip  <= '0;
            lane_done <= '0;
            lane_fail <= '0;
            train_cpl <= 1'b0;
            en_vtc    <= 1'b0;
            eye_width <= '0;
            for (int i = 0; i < LANES; i++) err_cnt[i] <= '0;
        end else begin
            bit_slip <= '0;
            case (state)
                S_IDLE: begin
                    lane     <= '0;
                    slip_cnt <= '0;
                    cur_len  <= '0;
                    best_len <= '0;
                    dly_cnt  <= '0;
                    for (int i = 0; i < LANES; i++) err_cnt[i] <= '0;
                    tmr      <= 16'(SETTLE_CYC - 1);
                    state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (tmr == 16'd0) begin
                        tmr     <= 16'(SAMPLE_CYC - 1);
                        pass_ok <= 1'b1;
                        state   <= S_SAMPLE;
                    end else tmr <= tmr - 16'd1;
                end
                S_SAMPLE: begin
                    if (cur_word != FC_PATTERN) pass_ok <= 1'b0;
                    if (tmr == 16'd0) state <= S_STEP;
                    else              tmr   <= tmr - 16'd1;
                end
                S_STEP: begin
                    if (pass_ok) begin
                        cur_start <= new_start;
                        cur_len   <= new_len;
                        if (new_len > best_len) begin
                            best_start <= new_start;
                            best_len   <= new_len;
                        end
                    end else cur_len <= '0;
                    if (next_dly <= (DLY_W+1)'(DLY_MAX)) begin
                        dly_cnt[lane*DLY_W +: DLY_W] <= next_dly[DLY_W-1:0];
                        tmr   <= 16'(SETTLE_CYC - 1);
                        state <= S_SETTLE;
                    end else state <= S_EVAL;
                end
                S_EVAL: begin
                    if (best_len >= 8'(MIN_EYE)) state <= S_CENTER;
                    else begin
                        bit_slip[lane] <= 1'b1;
                        state          <= S_SLIP;
                    end
                end
                S_SLIP: begin
                    // A re-sweep after a slip starts with fresh window trackers
                    dly_cnt[lane*DLY_W +: DLY_W] <= '0;
                    slip_cnt <= slip_cnt + 1'b1;
                    cur_len  <= '0;
                    best_len <= '0;
                    if (slip_cnt + 1'b1 == SLIP_W'(PAT_W)) begin
                        lane_fail[lane] <= 1'b1;
                        state           <= S_NEXT;
                    end else begin
                        tmr   <= 16'(SETTLE_CYC - 1);
                        state <= S_SETTLE;
                    end
                end
                S_CENTER: begin
                    dly_cnt[lane*DLY_W +: DLY_W] <= center_dly;
                    lane_done[lane]          <= 1'b1;
                    eye_width[lane*8 +: 8]   <= best_len;
                    state                    <= S_NEXT;
                end
                S_NEXT: begin
                    if (lane == LANE_W'(LANES - 1)) begin
                        if (lane_fail == '0) begin
                            train_cpl <= 1'b1;
                            en_vtc    <= 1'b1;
                            state     <= S_MONITOR;
                        end else state <= S_FAIL;
                    end else begin
                        lane     <= lane + 1'b1;
                        slip_cnt <= '0;
                        cur_len  <= '0;
                        best_len <= '0;
                        tmr      <= 16'(SETTLE_CYC - 1);
                        state    <= S_SETTLE;
                    end
                end
                S_MONITOR: begin
                    for (int i = 0; i < LANES; i++)
                        if (fc_patten[i*PAT_W +: PAT_W] != FC_PATTERN && err_cnt[i] != 16'hFFFF)
                            err_cnt[i] <= err_cnt[i] + 16'd1;
                    if (err_over) begin
                        if (retrain_cnt != 16'hFFFF) retrain_cnt <= retrain_cnt + 16'd1;
                        dly_cnt   <= '0;
                        lane_done <= '0;
                        lane_fail <= '0;
                        eye_width <= '0;
                        train_cpl <= 1'b0;
                        en_vtc    <= 1'b0;
                        for (int i = 0; i < LANES; i++) err_cnt[i] <= '0;
                        state     <= S_IDLE;
                    end
                end
                S_FAIL: state <= S_FAIL;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ad9253_lane_align_ctrl.sv
// Bench: behavioural deserialiser model (tap windows, slips needed) driving the
// aligner; expected taps/widths/slips derived from longest-run search over taps.
module tb_ad9253_lane_align_ctrl;
    localparam int LANES = 4;
    localparam int DLY_W = 9;
    localparam int PAT_W = 8;
    localparam int DMAX  = 450;
    localparam int STEP  = 10;
    localparam logic [7:0] FC = 8'hF0;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_rdy;
    logic [LANES*PAT_W-1:0] fc_patten = '0;
    logic [LANES*DLY_W-1:0] dly_cnt;
    logic [LANES-1:0]       bit_slip, lane_done, lane_fail;
    logic                   train_cpl, en_vtc;
    logic [LANES*8-1:0]     eye_width;
    logic [15:0]            retrain_cnt;

    ad9253_lane_align_ctrl #(.SETTLE_CYC(4), .SAMPLE_CYC(8)) dut (
        .clk(clk), .rst(rst), .cfg_rdy(cfg_rdy), .fc_patten(fc_patten),
        .dly_cnt(dly_cnt), .bit_slip(bit_slip), .lane_done(lane_done),
        .lane_fail(lane_fail), .train_cpl(train_cpl), .en_vtc(en_vtc),
        .eye_width(eye_width), .retrain_cnt(retrain_cnt)
    );

    always #5 clk = ~clk;

    int win_lo [LANES], win_hi [LANES], win2_lo [LANES], win2_hi [LANES], need [LANES];
    bit corrupt [LANES];
    int slip_seen [LANES] = '{default: 0};
    bit wide_slip [LANES] = '{default: 0};
    logic [LANES-1:0] prev_bs = '0;
    int checks = 0;
    int errors = 0;

    function automatic bit lane_pass(int i, int t, int s);
        return (s >= need[i]) &&
               ((t >= win_lo[i] && t <= win_hi[i]) || (t >= win2_lo[i] && t <= win2_hi[i]));
    endfunction

    // Deserialiser model: the word is the frame pattern only inside the eye
    always @(negedge clk) begin
        int t;
        logic [7:0] w;
        for (int i = 0; i < LANES; i++) begin
            if (rst) begin
                slip_seen[i] = 0;
                wide_slip[i] = 0;
            end else if (bit_slip[i]) begin
                slip_seen[i] = slip_seen[i] + 1;
                if (prev_bs[i]) wide_slip[i] = 1;
            end
            prev_bs[i] = bit_slip[i];
            t = int'(dly_cnt[i*DLY_W +: DLY_W]);
            if (!corrupt[i] && lane_pass(i, t, slip_seen[i])) fc_patten[i*PAT_W +: PAT_W] = FC;
            else begin
                w = 8'($urandom);
                if (w == FC) w = 8'h0F;
                fc_patten[i*PAT_W +: PAT_W] = w;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_all(input string tag, input int budget);
        int n = 0;
        while ((lane_done | lane_fail) != 4'hF && n < budget) begin
            tick(1);
            n++;
        end
        chk({tag, "_finished"}, 64'((lane_done | lane_fail) == 4'hF), 64'd1);
        tick(3);
    endtask

    function automatic int dly_of(int i);
        return int'(dly_cnt[i*DLY_W +: DLY_W]);
    endfunction

    // Expected outcome: longest run of passing taps (first wins), re-sweeping per slip
    function automatic void model(input int i, output int slips, output bit fail,
                                  output int ctr, output int wid);
        int best, bstart, len;
        for (int s = 0; s < PAT_W; s++) begin
            best = 0;
            bstart = 0;
            for (int t = 0; t <= DMAX; t += STEP) begin
                if (lane_pass(i, t, s) && (t == 0 || !lane_pass(i, t - STEP, s))) begin
                    len = 0;
                    while (t + STEP*len <= DMAX && lane_pass(i, t + STEP*len, s)) len++;
                    if (len > best) begin
                        best = len;
                        bstart = t;
                    end
                end
            end
            if (best >= 3) begin
                slips = s; fail = 0; wid = best; ctr = bstart + ((best - 1) / 2) * STEP;
                return;
            end
        end
        slips = PAT_W; fail = 1; ctr = 0; wid = 0;
    endfunction

    task automatic check_lanes(input string tag);
        int slips, ctr, wid;
        bit fail, any_fail;
        any_fail = 0;
        for (int i = 0; i < LANES; i++) begin
            model(i, slips, fail, ctr, wid);
            any_fail |= fail;
            chk($sformatf("%s_dly%0d", tag, i), 64'(dly_of(i)), 64'(ctr));
            chk($sformatf("%s_eye%0d", tag, i), 64'(eye_width[i*8 +: 8]), 64'(wid));
            chk($sformatf("%s_fail%0d", tag, i), 64'(lane_fail[i]), 64'(fail));
            chk($sformatf("%s_done%0d", tag, i), 64'(lane_done[i]), 64'(!fail));
            chk($sformatf("%s_slips%0d", tag, i), 64'(slip_seen[i]), 64'(slips));
            chk($sformatf("%s_slipw%0d", tag, i), 64'(wide_slip[i]), 64'd0);
        end
        chk({tag, "_train_cpl"}, 64'(train_cpl), 64'(!any_fail));
        chk({tag, "_en_vtc"}, 64'(en_vtc), 64'(!any_fail));
    endtask

    task automatic set_win(input int i, input int lo, input int hi, input int n);
        win_lo[i] = lo; win_hi[i] = hi; win2_lo[i] = -1; win2_hi[i] = -1; need[i] = n;
    endtask

    task automatic check_cleared(input string tag, input int rc);
        chk({tag, "_dly"}, 64'(dly_cnt), 64'd0);
        chk({tag, "_slip"}, 64'(bit_slip), 64'd0);
        chk({tag, "_done"}, 64'(lane_done), 64'd0);
        chk({tag, "_fail"}, 64'(lane_fail), 64'd0);
        chk({tag, "_cpl"}, 64'(train_cpl), 64'd0);
        chk({tag, "_vtc"}, 64'(en_vtc), 64'd0);
        chk({tag, "_eye"}, 64'(eye_width), 64'd0);
        chk({tag, "_retrain"}, 64'(retrain_cnt), 64'(rc));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        int lo, len;
        logic [LANES-1:0] done_snap;
        for (int i = 0; i < LANES; i++) corrupt[i] = 0;
        rst = 1'b1;
        cfg_rdy = 1'b0;
        set_win(0, 100, 200, 0);
        for (int i = 1; i < LANES; i++) set_win(i, 50, 90, 0);
        tick(3);
        check_cleared("reset", 0);

        // Basic training: lane0 100-200, others 50-90
        rst = 1'b0;
        cfg_rdy = 1'b1;
        wait_all("A", 8000);
        check_lanes("A");

        // Lane 3 corrupted: 4097 mismatches is the first count above the limit
        corrupt[3] = 1;
        tick(4097);
        chk("mon_hold_cpl", 64'(train_cpl), 64'd1);
        corrupt[3] = 0;
        tick(1);
        chk("retrain_cpl_drop", 64'(train_cpl), 64'd0);
        chk("retrain_cnt1", 64'(retrain_cnt), 64'd1);
        chk("retrain_done_clr", 64'(lane_done), 64'd0);

        // Drop cfg_rdy mid-sweep of the retrain
        tick(300);
        chk("mid_sweep_tap_moving", 64'(dly_of(0) != 0), 64'd1);
        cfg_rdy = 1'b0;
        tick(1);
        check_cleared("cfgdrop", 1);
        tick(5);
        cfg_rdy = 1'b1;
        wait_all("A_retrain", 8000);
        check_lanes("A_retrain");
        chk("A_retrain_cnt", 64'(retrain_cnt), 64'd1);

        // Reset in MONITOR; then lane 2 needs three slips
        set_win(2, 0, 40, 3);
        rst = 1'b1;
        tick(1);
        check_cleared("rst_monitor", 0);
        rst = 1'b0;
        wait_all("B", 15000);
        check_lanes("B");

        // Lane 1 never passes: eight slips, lane_fail, terminal FAIL
        set_win(2, 50, 90, 0);
        set_win(1, 50, 90, 255);
        do_reset();
        wait_all("C", 15000);
        check_lanes("C");
        done_snap = lane_done;
        tick(500);
        chk("C_fail_cpl_hold", 64'(train_cpl), 64'd0);
        chk("C_fail_no_more_slips", 64'(slip_seen[1]), 64'(PAT_W));
        chk("C_fail_done_hold", 64'(lane_done), 64'(done_snap));

        // Two equal windows on lane 0: lowest-tap window wins
        set_win(0, 0, 20, 0);
        win2_lo[0] = 300;
        win2_hi[0] = 320;
        for (int i = 1; i < LANES; i++) begin
            lo = STEP * $urandom_range(0, 40);
            set_win(i, lo, lo + STEP * $urandom_range(3, 8), 0);
        end
        do_reset();
        wait_all("D", 8000);
        check_lanes("D");

        // Randomised windows, second windows and slip requirements
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < LANES; i++) begin
                lo  = STEP * $urandom_range(0, 45);
                len = $urandom_range(2, 12);
                set_win(i, lo, (lo + STEP*(len - 1) > DMAX) ? DMAX : lo + STEP*(len - 1),
                        $urandom_range(0, 2));
                if ($urandom_range(0, 1) == 1) begin
                    win2_lo[i] = STEP * $urandom_range(0, 45);
                    win2_hi[i] = win2_lo[i] + STEP * $urandom_range(0, 6);
                end
            end
            do_reset();
            wait_all($sformatf("R%0d", it), 25000);
            check_lanes($sformatf("R%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
